byte_load_ctrl: RTL and testbench
=================================

// Module: byte_load_ctrl
// PURPOSE
//  Sequences sub-word loads (lb/lbu, optional lh/lhu) between the core and a word-wide data memory.
//  Fetches the aligned word, selects the addressed byte/half, then sign- or zero-extends it to 32 bits.
//  Returns the result to the register-file write-back path as a one-cycle pulse.
//  Sits between the load/store decode stage and the data-memory port; the core stalls while ld_ready=0.
// PARAMETERS
//  MAX_WAIT  15  cycles mem_req may stay high without mem_ack before the load aborts with wb_err (1..255)
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   synchronous, active-high reset
//  ld_valid   in   1   load request from decode
//  ld_ready   out  1   controller idle, can accept a request
//  ld_addr    in   32  byte address
//  ld_signed  in   1   1=sign-extend, 0=zero-extend
//  ld_size    in   2   00=byte, 01=half (01 honoured only with LOAD_HALF_EN)
//  mem_req    out  1   memory read request, held until ack/timeout
//  mem_addr   out  32  word-aligned address {addr[31:2],2'b00}
//  mem_ack    in   1   read data valid this cycle
//  mem_rdata  in   32  read word, little-endian
//  wb_valid   out  1   one-cycle result strobe
//  wb_data    out  32  extended result, held until next accept
//  wb_err     out  1   qualifies wb_valid: timeout or misaligned half
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE, ld_ready=1; mem_req, wb_valid, wb_err=0; wb_data, mem_addr, wait counter=0.
//  Reset mid-operation: abandon the load, no wb_valid; a late mem_ack in IDLE is ignored.
//  FSM states IDLE, REQ, RESP; all outputs registered.
//  IDLE: ld_ready=1. When ld_valid=1, latch addr/signed/size; next state REQ.
//    Misaligned half (LOAD_HALF_EN, size=01, addr[0]=1): go to RESP with wb_err=1, wb_data=0, no mem_req.
//  REQ: mem_req=1 and mem_addr stable; ld_ready=0; wait counter increments each cycle without ack.
//    mem_ack=1: register extracted/extended data; next state RESP.
//    Counter reaches MAX_WAIT with no ack: wb_data=0, wb_err=1, go to RESP.
//    Ack in the same cycle the counter hits MAX_WAIT: ack wins, no error.
//  RESP: wb_valid=1 for exactly one cycle; mem_req=0; next state IDLE; counter cleared.
//  Latency: accept edge N, mem_req high N+1; ack at edge M gives wb_valid in cycle M+1; min 3 cycles accept-to-result.
//  ld_valid while ld_ready=0 is ignored (not queued); mem_ack outside REQ is ignored.
//  Byte select by addr[1:0]: 00->[7:0], 01->[15:8], 10->[23:16], 11->[31:24].
//  Half select by addr[1]: 0->[15:0], 1->[31:16].
//  Extension: signed copies the top selected bit into all upper bits; unsigned zero-fills them.
//  wb_data/wb_err hold their values after wb_valid drops until the next accept.
// CONFIGURATION
//  LOAD_HALF_EN defined: ld_size=01 gives halfword loads with misalignment check.
//  LOAD_HALF_EN undefined: ld_size ignored; every load is a byte load; no misaligned error path.
// STRUCTURE
//  Package mips_pkg: state enum (ST_IDLE/ST_REQ/ST_RESP), LD_BYTE=2'b00 / LD_HALF=2'b01, DATA_W=32.
//  Sub-module load_extend (combinational): {word, offset, size, signed} -> 32-bit extended value.
//  byte_load_ctrl keeps only the FSM, wait counter and output registers.
// TESTING
//  lb  addr=0x1003, signed, rdata=0x80AABBCC, ack after 2 cycles -> wb_data=0xFFFFFF80, mem_addr=0x1000, wb_err=0.
//  lbu addr=0x1001, rdata=0x1234F678, ack next cycle -> wb_data=0x000000F6, wb_valid exactly 1 cycle.
//  No ack, MAX_WAIT=4 -> mem_req high 4 cycles, then wb_valid=1, wb_err=1, wb_data=0.
//  LOAD_HALF_EN: lh addr=0x2002, rdata=0x8001_0000 -> 0xFFFF8001; lh addr=0x2001 -> wb_err=1, no mem_req.
//  reset asserted while in REQ -> next cycle mem_req=0, ld_ready=1; later mem_ack ignored; no wb_valid.
//  ld_valid held high throughout a busy load -> exactly one load performed; next accept occurs only after RESP.

Source files
------------

// File: rtl/byte_load_ctrl_pkg.sv
// mips_pkg: shared types and constants for the sub-word load controller.
package mips_pkg;

  localparam int DATA_W = 32;

  // Encodings of the ld_size request field.
  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/byte_load_ctrl_if.sv
// byte_load_ctrl_if: groups the decode-side request, data-memory port and
// write-back result of the sub-word load controller.
interface byte_load_ctrl_if;
  import mips_pkg::*;

  // Decode side
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_addr;
  logic              ld_signed;
  logic [1:0]        ld_size;
  // Data-memory side
  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  // Write-back side
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic              wb_err;

  // The controller itself.
  modport slave (
    input  ld_valid, ld_addr, ld_signed, ld_size, mem_ack, mem_rdata,
    output ld_ready, mem_req, mem_addr, wb_valid, wb_data, wb_err
  );

  // Whatever drives requests and models the memory (core + memory).
  modport master (
    output ld_valid, ld_addr, ld_signed, ld_size, mem_ack, mem_rdata,
    input  ld_ready, mem_req, mem_addr, wb_valid, wb_data, wb_err
  );

endinterface

// File: rtl/byte_load_ctrl_extend.sv
// load_extend: picks the addressed byte or halfword out of a little-endian
// word and sign- or zero-extends it to DATA_W bits. Purely combinational.
module load_extend
  import mips_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        offset_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension of the selected lane's top bit.
  always_comb begin
    byte_sel = word_i[7:0];
    case (offset_i)
      2'b00:   byte_sel = word_i[7:0];
      2'b01:   byte_sel = word_i[15:8];
      2'b10:   byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

    if (size_i == LD_HALF) begin
      data_o = {{16{signed_i & half_sel[15]}}, half_sel};
    end else begin
      data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
    end
  end

endmodule

// File: rtl/byte_load_ctrl.sv
// byte_load_ctrl: sequences lb/lbu loads against a word-wide data memory,
// returning the extended result as a one-cycle write-back pulse.
// Build option: define LOAD_HALF_EN to honour ld_size=01 (lh/lhu) together
// with the misaligned-halfword error path. Without it every load is a byte load.
module byte_load_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15  // 1..255 cycles of mem_req without ack
) (
  input  logic            clk,
  input  logic            reset,
  byte_load_ctrl_if.slave bus
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_t            state_q, state_d;
  logic              ld_ready_q, ld_ready_d;
  logic              mem_req_q, mem_req_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_err_q, wb_err_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [1:0]        req_size;
  logic              misaligned;
  logic              timeout;
  logic [DATA_W-1:0] ext_data;

`ifdef LOAD_HALF_EN
  assign req_size   = bus.ld_size;
  assign misaligned = (bus.ld_size == LD_HALF) && bus.ld_addr[0];
`else
  // Size field is ignored in a byte-only build.
  logic unused_size;
  assign unused_size = ^bus.ld_size;
  assign req_size    = LD_BYTE;
  assign misaligned  = 1'b0;
`endif

  // The limit is reached on the cycle whose increment would hit MAX_WAIT;
  // an ack on that same cycle takes priority.
  assign timeout = !bus.mem_ack && ((cnt_q + 8'd1) == WAIT_LIMIT);

  load_extend u_extend (
    .word_i   (bus.mem_rdata),
    .offset_i (off_q),
    .size_i   (size_q),
    .signed_i (sgn_q),
    .data_o   (ext_data)
  );

  // State and output register bank with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ld_ready_q <= 1'b1;
      mem_req_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_err_q   <= 1'b0;
      mem_addr_q <= '0;
      wb_data_q  <= '0;
      off_q      <= '0;
      size_q     <= LD_BYTE;
      sgn_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ld_ready_q <= ld_ready_d;
      mem_req_q  <= mem_req_d;
      wb_valid_q <= wb_valid_d;
      wb_err_q   <= wb_err_d;
      mem_addr_q <= mem_addr_d;
      wb_data_q  <= wb_data_d;
      off_q      <= off_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic.
  // NOTE: every variable written in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.ld_valid) state_d = misaligned ? ST_RESP : ST_REQ;
      ST_REQ:  if (bus.mem_ack || timeout) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; handshake outputs follow the next state
  // so they are registered yet aligned with it.
  always_comb begin
    mem_addr_d = mem_addr_q;
    off_d      = off_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    wb_data_d  = wb_data_q;
    wb_err_d   = wb_err_q;
    cnt_d      = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.ld_valid) begin
          mem_addr_d = {bus.ld_addr[DATA_W-1:2], 2'b00};
          off_d      = bus.ld_addr[1:0];
          size_d     = req_size;
          sgn_d      = bus.ld_signed;
          if (misaligned) begin
            wb_data_d = '0;
            wb_err_d  = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (bus.mem_ack) begin
          wb_data_d = ext_data;
          wb_err_d  = 1'b0;
        end else if (timeout) begin
          wb_data_d = '0;
          wb_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase

    ld_ready_d = (state_d == ST_IDLE);
    mem_req_d  = (state_d == ST_REQ);
    wb_valid_d = (state_d == ST_RESP);
  end

  assign bus.ld_ready = ld_ready_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.wb_err   = wb_err_q;

endmodule

// File: tb/tb_byte_load_ctrl.sv
// tb_byte_load_ctrl: directed and random sub-word loads against an
// arithmetic reference model of byte/half selection and extension.
module tb_byte_load_ctrl;
  import mips_pkg::*;

  localparam int unsigned MAX_WAIT = 4;
`ifdef LOAD_HALF_EN
  localparam bit HALF_EN = 1'b1;
`else
  localparam bit HALF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  byte_load_ctrl_if bus ();

  byte_load_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit is_half(input logic [1:0] size);
    return HALF_EN && (size == 2'b01);
  endfunction

  // Reference: take the addressed lane as a number, then reinterpret it as
  // two's complement when a signed load has its top bit set.
  function automatic logic [31:0] ref_data(input logic [31:0] word, input logic [31:0] addr,
                                           input logic sgn, input logic [1:0] size);
    int unsigned width;
    int unsigned lane;
    longint      v;
    width = is_half(size) ? 16 : 8;
    lane  = addr[1:0] / (width / 8);
    v     = longint'(word >> (lane * width)) % (longint'(1) << width);
    if (sgn && v >= (longint'(1) << (width - 1))) v -= (longint'(1) << width);
    return 32'(v);
  endfunction

  // One complete load. ack_after = number of REQ cycles before the ack cycle
  // (negative = never acknowledge).
  task automatic run_load(input string tag, input logic [31:0] addr, input logic sgn,
                          input logic [1:0] size, input logic [31:0] rdata,
                          input int ack_after, input bit hold_valid);
    bit          misal;
    bit          tmo;
    bit          got;
    logic [31:0] exp_data;
    int          exp_req;
    int          req_cycles;
    misal    = is_half(size) && addr[0];
    tmo      = !misal && (ack_after < 0 || ack_after >= int'(MAX_WAIT));
    exp_data = (misal || tmo) ? 32'h0 : ref_data(rdata, addr, sgn, size);
    exp_req  = tmo ? int'(MAX_WAIT) : ack_after + 1;

    bus.ld_valid  = 1'b1;
    bus.ld_addr   = addr;
    bus.ld_signed = sgn;
    bus.ld_size   = size;
    @(posedge clk); #1;
    if (!hold_valid) bus.ld_valid = 1'b0;
    bus.ld_addr   = $urandom;
    bus.ld_signed = 1'($urandom);
    bus.ld_size   = 2'($urandom);
    check({tag, "/busy"}, bus.ld_ready, 0);

    if (misal) begin
      check({tag, "/no_req"}, bus.mem_req, 0);
      check({tag, "/valid"}, bus.wb_valid, 1);
      check({tag, "/err"}, bus.wb_err, 1);
      check({tag, "/data"}, bus.wb_data, 0);
    end else begin
      check({tag, "/mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
      req_cycles = 0;
      got        = 1'b0;
      for (int c = 0; c < 64 && !got; c++) begin
        if (bus.mem_req) req_cycles++;
        bus.mem_ack   = (c == ack_after);
        bus.mem_rdata = (c == ack_after) ? rdata : $urandom;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        got = bus.wb_valid;
        if (!got) check({tag, "/wait_busy"}, bus.ld_ready, 0);
      end
      check({tag, "/result_seen"}, got, 1);
      check({tag, "/req_cycles"}, req_cycles, exp_req);
      check({tag, "/data"}, bus.wb_data, exp_data);
      check({tag, "/err"}, bus.wb_err, tmo);
      check({tag, "/req_drop"}, bus.mem_req, 0);
    end

    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    check({tag, "/pulse"}, bus.wb_valid, 0);
    check({tag, "/ready"}, bus.ld_ready, 1);
    check({tag, "/data_hold"}, bus.wb_data, exp_data);

    // Stray ack while idle must not produce a result or disturb held data.
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = $urandom;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    check({tag, "/idle_ack"}, bus.wb_valid, 0);
    check({tag, "/err_hold"}, bus.wb_err, misal || tmo);
    check({tag, "/data_hold2"}, bus.wb_data, exp_data);
  endtask

  initial begin
    bus.ld_valid  = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_signed = 1'b0;
    bus.ld_size   = 2'b00;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst/ready", bus.ld_ready, 1);
    check("rst/mem_req", bus.mem_req, 0);
    check("rst/wb_valid", bus.wb_valid, 0);
    check("rst/wb_err", bus.wb_err, 0);
    check("rst/wb_data", bus.wb_data, 0);
    check("rst/mem_addr", bus.mem_addr, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_load("lb_neg", 32'h0000_1003, 1'b1, 2'b00, 32'h80AA_BBCC, 2, 1'b0);
    run_load("lbu", 32'h0000_1001, 1'b0, 2'b00, 32'h1234_F678, 0, 1'b0);
    run_load("timeout", 32'h0000_4000, 1'b1, 2'b00, 32'hFFFF_FFFF, -1, 1'b0);
    run_load("ack_at_limit", 32'h0000_5002, 1'b1, 2'b00, 32'h007F_0000, int'(MAX_WAIT) - 1, 1'b0);
`ifdef LOAD_HALF_EN
    run_load("lh", 32'h0000_2002, 1'b1, 2'b01, 32'h8001_0000, 1, 1'b0);
    run_load("lh_misal", 32'h0000_2001, 1'b1, 2'b01, 32'h0000_0000, 0, 1'b0);
`endif
    run_load("held_valid", 32'h0000_3002, 1'b0, 2'b00, 32'hA5C3_1122, 1, 1'b1);

    // Reset while a request is outstanding abandons it.
    bus.ld_valid  = 1'b1;
    bus.ld_addr   = 32'h0000_6001;
    bus.ld_signed = 1'b0;
    bus.ld_size   = 2'b00;
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    check("rst_mid/req", bus.mem_req, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid/req_drop", bus.mem_req, 0);
    check("rst_mid/ready", bus.ld_ready, 1);
    check("rst_mid/no_valid", bus.wb_valid, 0);
    check("rst_mid/mem_addr", bus.mem_addr, 0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    check("rst_mid/late_ack", bus.wb_valid, 0);
    check("rst_mid/late_req", bus.mem_req, 0);
    check("rst_mid/late_data", bus.wb_data, 0);

    for (int i = 0; i < 24; i++) begin
      run_load("rand", $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               $urandom, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
